// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundles the handshake and bus signals around pipe_ctrl.
//                master : pipeline / memory-controller side. It drives the
//                         requests and port_done_i, and receives the grants,
//                         dones, stall vector and jump flag.
//                slave  : pipe_ctrl itself.
//                Signal names keep the _i/_o suffixes as seen from pipe_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int STALL_W = 6,
    parameter int ADDR_W  = 32
);
    logic               if_req_i;
    logic [ADDR_W-1:0]  if_addr_i;
    logic               mem_req_i;
    logic [ADDR_W-1:0]  mem_addr_i;
    logic               mem_wr_i;
    logic               id_stall_req_i;
    logic               ex_jump_i;
    logic               port_done_i;
    logic               port_start_o;
    logic [ADDR_W-1:0]  port_addr_o;
    logic               port_wr_o;
    logic               port_owner_o;
    logic               if_done_o;
    logic               mem_done_o;
    logic [STALL_W-1:0] stall_signal_o;
    logic               jump_flag_o;

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_addr_i, mem_wr_i,
               id_stall_req_i, ex_jump_i, port_done_i,
        input  port_start_o, port_addr_o, port_wr_o, port_owner_o,
               if_done_o, mem_done_o, stall_signal_o, jump_flag_o
    );

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_addr_i, mem_wr_i,
               id_stall_req_i, ex_jump_i, port_done_i,
        output port_start_o, port_addr_o, port_wr_o, port_owner_o,
               if_done_o, mem_done_o, stall_signal_o, jump_flag_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central hazard/stall controller.
//                - Arbitrates the single memory port between IF fetches and
//                  MEM loads/stores. MEM wins a simultaneous request.
//                - Produces the stall vector
//                  (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB) and the jump flag.
//                - Discards a fetch that is in flight when EX resolves a jump.
//  Ports       : clk, rst        clock and synchronous active-high reset
//                bus (slave)     requests, port handshake, stall/jump outputs
//                stall_cnt_o     cycles with a non-zero stall vector
//                                (PIPE_CTRL_PERF_EN only)
//                flush_cnt_o     cycles with jump_flag_o set
//                                (PIPE_CTRL_PERF_EN only)
//  Config      : define PIPE_CTRL_PERF_EN to add the two perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int STALL_W = 6,
    parameter int ADDR_W  = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam logic [STALL_W-1:0] c_STALL_MEM  = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] c_STALL_ID   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] c_STALL_IF   = STALL_W'(6'b000011);
    localparam logic [STALL_W-1:0] c_STALL_NONE = '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IF_BUSY  = 2'd1,
        S_MEM_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_start;
    logic                r_discard;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic                w_if_done;
    logic                w_mem_done;
    logic [STALL_W-1:0]  w_stall;
    logic                w_jump_flag;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and launch decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_req_i) begin
                    w_state_nxt = S_MEM_BUSY;
                    w_start     = 1'b1;
                end else if (bus.if_req_i) begin
                    w_state_nxt = S_IF_BUSY;
                    w_start     = 1'b1;
                end
            end
            S_IF_BUSY, S_MEM_BUSY: begin
                if (bus.port_done_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Launch address/write flag, captured in the launch cycle and held
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_wr   <= 1'b0;
        end else if (w_start) begin
            r_addr <= bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
            r_wr   <= bus.mem_req_i & bus.mem_wr_i;
        end
    end

    // ------------------------------------------------------------------
    // Discard flag: remembers a jump seen while a fetch is in flight so
    // the stale instruction is not delivered when the port completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_discard <= 1'b0;
        end else if (r_state == S_IF_BUSY) begin
            if (bus.port_done_i) begin
                r_discard <= 1'b0;
            end else if (bus.ex_jump_i) begin
                r_discard <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational outputs, all forced low while rst is asserted
    // ------------------------------------------------------------------
    assign w_mem_done = !rst && (r_state == S_MEM_BUSY) && bus.port_done_i;
    // A jump arriving in the done cycle itself also kills the fetch.
    assign w_if_done  = !rst && (r_state == S_IF_BUSY) && bus.port_done_i
                        && !(r_discard || bus.ex_jump_i);

    always_comb begin
        w_stall = c_STALL_NONE;
        if (!rst) begin
            if (bus.mem_req_i && !w_mem_done) begin
                w_stall = c_STALL_MEM;
            end else if (bus.id_stall_req_i) begin
                w_stall = c_STALL_ID;
            end else if (bus.if_req_i && !w_if_done) begin
                w_stall = c_STALL_IF;
            end
        end
    end

    // EX is frozen during a MEM stall and keeps presenting the jump, so
    // the flush is taken only once the stall lifts.
    assign w_jump_flag = !rst && bus.ex_jump_i && !w_stall[4];

    assign bus.port_start_o   = !rst && w_start;
    assign bus.port_addr_o    = rst ? '0 : r_addr;
    assign bus.port_wr_o      = !rst && r_wr;
    assign bus.port_owner_o   = !rst && (r_state == S_MEM_BUSY);
    assign bus.if_done_o      = w_if_done;
    assign bus.mem_done_o     = w_mem_done;
    assign bus.stall_signal_o = w_stall;
    assign bus.jump_flag_o    = w_jump_flag;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall != c_STALL_NONE) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_jump_flag) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl. A directed vector table
//                with hand-derived expectations, followed by random stimulus
//                checked against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STALL_W(6), .ADDR_W(32)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_ctrl #(.STALL_W(6), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        mreq;
        logic [31:0] maddr;
        logic        mwr;
        logic        idst;
        logic        jmp;
        logic        done;
        logic        start;
        logic        owner;
        logic        idone;
        logic        mdone;
        logic [5:0]  stall;
        logic        jf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic r, logic ireq, logic [31:0] ia, logic mreq, logic [31:0] ma,
        logic mwr, logic idst, logic jmp, logic done,
        logic start, logic owner, logic idone, logic mdone,
        logic [5:0] st, logic jf);
        vec_t v;
        v.rst = r;     v.ireq = ireq; v.iaddr = ia;  v.mreq = mreq;
        v.maddr = ma;  v.mwr = mwr;   v.idst = idst; v.jmp = jmp;
        v.done = done; v.start = start; v.owner = owner;
        v.idone = idone; v.mdone = mdone; v.stall = st; v.jf = jf;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks the one outstanding port transaction
    // ------------------------------------------------------------------
    int          m_busy = 0;        // 0 none, 1 fetch, 2 load/store
    bit          m_killed = 1'b0;   // fetch already invalidated by a jump
    logic [31:0] m_addr = '0;
    logic        m_wr = 1'b0;
    logic [31:0] m_scnt = '0;
    logic [31:0] m_fcnt = '0;

    logic        e_start, e_owner, e_idone, e_mdone, e_jf, e_wr;
    logic [5:0]  e_stall;
    logic [31:0] e_addr;

    task automatic model_eval(input vec_t v);
        e_start = 0; e_owner = 0; e_idone = 0; e_mdone = 0;
        e_jf = 0; e_wr = 0; e_stall = 6'd0; e_addr = '0;
        if (!v.rst) begin
            e_start = (m_busy == 0) && (v.ireq || v.mreq);
            e_owner = (m_busy == 2);
            e_mdone = (m_busy == 2) && v.done;
            e_idone = (m_busy == 1) && v.done && !(m_killed || v.jmp);
            if (v.mreq && !e_mdone)      e_stall = 6'b011111;
            else if (v.idst)             e_stall = 6'b000111;
            else if (v.ireq && !e_idone) e_stall = 6'b000011;
            e_jf   = v.jmp && (e_stall != 6'b011111);
            e_addr = m_addr;
            e_wr   = m_wr;
        end
    endtask

    task automatic model_step(input vec_t v);
        if (v.rst) begin
            m_busy = 0; m_killed = 0; m_addr = '0; m_wr = 0;
            m_scnt = '0; m_fcnt = '0;
        end else begin
            if (e_stall != 0) m_scnt = m_scnt + 1;
            if (e_jf)         m_fcnt = m_fcnt + 1;
            if (m_busy == 0) begin
                if (v.mreq) begin
                    m_busy = 2; m_addr = v.maddr; m_wr = v.mwr;
                end else if (v.ireq) begin
                    m_busy = 1; m_addr = v.iaddr; m_wr = 0;
                end
            end else if (v.done) begin
                m_busy = 0; m_killed = 0;
            end else if (m_busy == 1 && v.jmp) begin
                m_killed = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst                = v.rst;
        bus.if_req_i       = v.ireq;
        bus.if_addr_i      = v.iaddr;
        bus.mem_req_i      = v.mreq;
        bus.mem_addr_i     = v.maddr;
        bus.mem_wr_i       = v.mwr;
        bus.id_stall_req_i = v.idst;
        bus.ex_jump_i      = v.jmp;
        bus.port_done_i    = v.done;
    endtask

    // One clock: drive on negedge, check mid-cycle, advance model at posedge.
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        @(negedge clk);
        apply(v);
        #1;
        model_eval(v);
        chk({tag, " start"}, 32'(bus.port_start_o), 32'(e_start));
        chk({tag, " owner"}, 32'(bus.port_owner_o), 32'(e_owner));
        chk({tag, " if_done"}, 32'(bus.if_done_o), 32'(e_idone));
        chk({tag, " mem_done"}, 32'(bus.mem_done_o), 32'(e_mdone));
        chk({tag, " stall"}, 32'(bus.stall_signal_o), 32'(e_stall));
        chk({tag, " jump_flag"}, 32'(bus.jump_flag_o), 32'(e_jf));
        chk({tag, " addr"}, bus.port_addr_o, e_addr);
        chk({tag, " wr"}, 32'(bus.port_wr_o), 32'(e_wr));
`ifdef PIPE_CTRL_PERF_EN
        if (!v.rst) begin
            chk({tag, " stall_cnt"}, stall_cnt, m_scnt);
            chk({tag, " flush_cnt"}, flush_cnt, m_fcnt);
        end
`endif
        if (use_tbl) begin
            chk({tag, " tbl_start"}, 32'(bus.port_start_o), 32'(v.start));
            chk({tag, " tbl_owner"}, 32'(bus.port_owner_o), 32'(v.owner));
            chk({tag, " tbl_if_done"}, 32'(bus.if_done_o), 32'(v.idone));
            chk({tag, " tbl_mem_done"}, 32'(bus.mem_done_o), 32'(v.mdone));
            chk({tag, " tbl_stall"}, 32'(bus.stall_signal_o), 32'(v.stall));
            chk({tag, " tbl_jump_flag"}, 32'(bus.jump_flag_o), 32'(v.jf));
        end
        @(posedge clk);
        model_step(v);
    endtask

    initial begin
        vec_t v;
        //            rst ire iaddr     mrq maddr     wr  ids jmp dn  st  own id  md  stall      jf
        // reset with requests pending
        tbl.push_back(mk(1, 1, 32'h100, 1, 32'h200, 1, 1, 1, 1, 0, 0, 0, 0, 6'b000000, 0));
        tbl.push_back(mk(1, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        // fetch 0x100: launch, three busy cycles, done
        tbl.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 1, 0, 0, 0, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 0, 6'b000000, 0));
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 0));
        // simultaneous IF and MEM: MEM wins, IF launches after mem_done
        tbl.push_back(mk(0, 1, 32'h104, 1, 32'h200, 1, 0, 0, 0, 1, 0, 0, 0, 6'b011111, 0));
        tbl.push_back(mk(0, 1, 32'h104, 1, 32'h200, 1, 0, 0, 0, 0, 1, 0, 0, 6'b011111, 0));
        tbl.push_back(mk(0, 1, 32'h104, 1, 32'h200, 1, 0, 0, 1, 0, 1, 0, 1, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h104, 0, 32'h0,   0, 0, 0, 0, 1, 0, 0, 0, 6'b000011, 0));
        // jump during fetch: flush now, fetch discarded at done
        tbl.push_back(mk(0, 1, 32'h104, 0, 32'h0,   0, 0, 1, 0, 0, 0, 0, 0, 6'b000011, 1));
        tbl.push_back(mk(0, 1, 32'h104, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h104, 0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 0, 6'b000011, 0));
        // load-use stall only while requested
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 0, 0, 0, 0, 6'b000111, 0));
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 0, 0, 0, 0, 6'b000111, 0));
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        // jump held across MEM stall: flag only at mem_done
        tbl.push_back(mk(0, 0, 32'h0,   1, 32'h300, 0, 0, 1, 0, 1, 0, 0, 0, 6'b011111, 0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 32'h300, 0, 0, 1, 0, 0, 1, 0, 0, 6'b011111, 0));
        tbl.push_back(mk(0, 0, 32'h0,   1, 32'h300, 0, 0, 1, 1, 0, 1, 0, 1, 6'b000000, 1));
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        // jump in IDLE must not poison the fetch it launches alongside
        tbl.push_back(mk(0, 1, 32'h108, 0, 32'h0,   0, 0, 1, 0, 1, 0, 0, 0, 6'b000011, 1));
        tbl.push_back(mk(0, 1, 32'h108, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0));
        tbl.push_back(mk(0, 1, 32'h108, 0, 32'h0,   0, 0, 0, 1, 0, 0, 1, 0, 6'b000000, 0));
        // reset mid-access, later done ignored
        tbl.push_back(mk(0, 0, 32'h0,   1, 32'h400, 1, 0, 0, 0, 1, 0, 0, 0, 6'b011111, 0));
        tbl.push_back(mk(1, 0, 32'h0,   1, 32'h400, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 0));
        tbl.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
            v.rst   = ($urandom_range(0, 99) == 0);
            v.ireq  = $urandom_range(0, 1) == 1;
            v.iaddr = $urandom;
            v.mreq  = ($urandom_range(0, 3) == 0);
            v.maddr = $urandom;
            v.mwr   = $urandom_range(0, 1) == 1;
            v.idst  = ($urandom_range(0, 7) == 0);
            v.jmp   = ($urandom_range(0, 5) == 0);
            v.done  = ($urandom_range(0, 2) == 0);
            run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
